// File: rtl/if_fetch_queue.sv
// Fetch unit: PC sequencing, single-outstanding icache requests, and a
// DEPTH-entry instruction FIFO toward decode with redirect flushing.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h6000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            imem_resp,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            imem_read,
  output logic [XLEN-1:0] imem_address,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_next,
  output logic [XLEN-1:0] out_ir,
  output logic [15:0]     flush_count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {FETCH, DROP, WAIT} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] req_pc, req_pc_next;
  logic [XLEN-1:0] stale_pc, stale_pc_next;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] ir_mem [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [AW:0]     count, count_next;
  logic [XLEN-1:0] target;
  logic            enq, deq;

  // Masking (rather than slicing) keeps every redirect_pc bit in use.
  assign target = redirect_pc & ~XLEN'(3);

  assign out_valid = (count != '0);
  assign deq       = out_valid & out_ready & ~redirect;
  assign enq       = (state == FETCH) & imem_resp & ~redirect;

  assign imem_read    = rst & (state != WAIT);
  assign imem_address = (state == DROP) ? stale_pc : req_pc;

  assign out_pc      = out_valid ? pc_mem[head] : '0;
  assign out_pc_next = out_valid ? pc_mem[head] + XLEN'(4) : '0;
  assign out_ir      = out_valid ? ir_mem[head] : '0;

  always_comb begin
    state_next    = state;
    req_pc_next   = req_pc;
    stale_pc_next = stale_pc;
    count_next    = count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
    if (redirect) count_next = '0;

    case (state)
      FETCH: begin
        if (redirect) begin
          req_pc_next = target;
          if (!imem_resp) begin
            state_next    = DROP;
            stale_pc_next = req_pc;
          end
        end else if (imem_resp) begin
          req_pc_next = req_pc + XLEN'(4);
          if (count_next == FULL) state_next = WAIT;
        end
      end
      // The stale address stays on the bus until its response retires it.
      DROP: begin
        if (redirect) req_pc_next = target;
        if (imem_resp) state_next = FETCH;
      end
      WAIT: begin
        if (redirect) begin
          req_pc_next = target;
          state_next  = FETCH;
        end else if (deq) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= FETCH;
      req_pc      <= RESET_PC;
      stale_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      flush_count <= '0;
    end else begin
      state    <= state_next;
      req_pc   <= req_pc_next;
      stale_pc <= stale_pc_next;
      count    <= count_next;
      if (redirect) begin
        head <= '0;
        tail <= '0;
        if (flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
      end else begin
        if (enq) tail <= tail + AW'(1);
        if (deq) head <= head + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail] <= req_pc;
      ir_mem[tail] <= imem_rdata;
    end
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised fetch unit for the RV32I pipeline. It holds the program counter and issues sequential instruction fetches to the icache with a valid/resp handshake, keeping at most one request outstanding. Returned instructions go into a DEPTH-entry FIFO that decouples the icache from decode stalls. It also absorbs branch/jump redirects by flushing the FIFO and discarding any in-flight stale response. Sits between the icache and the IF/ID boundary; decode pulls entries with a valid/ready handshake.

Parameters:
XLEN, 32, data and address width
DEPTH, 4, FIFO entries; power of 2, at least 2
RESET_PC, 32'h6000_0000, fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
redirect  in  1  branch/jump taken; redirect_pc is valid this cycle
redirect_pc  in  XLEN  redirect target
imem_resp  in  1  icache response; imem_rdata valid this cycle
imem_rdata  in  XLEN  fetched instruction
imem_read  out  1  fetch request
imem_address  out  XLEN  fetch address
out_valid  out  1  FIFO head is valid
out_ready  in  1  decode accepts the head this cycle
out_pc  out  XLEN  PC of the head instruction
out_pc_next  out  XLEN  out_pc + 4, for rvfi_pc_wdata
out_ir  out  XLEN  head instruction word
flush_count  out  16  number of redirects since reset; saturates at 16'hFFFF

Behaviour:
- Reset (rst=0, async):
  - state=FETCH, req_pc=RESET_PC, FIFO empty (head/tail/count=0), flush_count=0.
  - Outputs during reset: imem_read=0, out_valid=0, out_pc/out_pc_next/out_ir=0.
- Reset may occur mid-request. Any response that arrives after reset deasserts is not tagged as stale; the icache is reset by the same rst.
- FSM states:
  - FETCH: request outstanding.
  - DROP: outstanding request is stale.
  - WAIT: FIFO full, no request.
- Outputs by state:
  - imem_read=1 in FETCH and DROP; 0 in WAIT.
  - imem_address=req_pc. It is held stable from the start of a request until the cycle imem_resp=1 inclusive; the icache requires a stable address.
- FETCH, imem_resp=1, redirect=0:
  - Enqueue {req_pc, imem_rdata}; req_pc += 4, wrapping modulo 2^XLEN.
  - Next state is WAIT if the post-cycle count equals DEPTH, otherwise FETCH.
  - A new request issues the cycle after the response.
- FETCH, imem_resp=0, redirect=1: req_pc=target, FIFO flushed, next state DROP.
- FETCH, imem_resp=1, redirect=1: response discarded (no enqueue), req_pc=target, FIFO flushed, next state FETCH.
- DROP:
  - imem_address stays at the stale address until imem_resp.
  - On imem_resp, the data is discarded and next state is FETCH with imem_address=req_pc.
  - Redirect in DROP updates the pending target and stays in DROP.
  - DROP never enqueues.
- WAIT:
  - Leave to FETCH when a dequeue occurs (count < DEPTH next cycle); the request issues the following cycle.
  - Redirect in WAIT: flush, req_pc=target, next state FETCH.
- Target forming: target = {redirect_pc[XLEN-1:2], 2'b00}. There is no compressed ISA, and the JALR bit-0 clear is subsumed.
- Redirect priority:
  - Redirect has priority over a dequeue in the same cycle; the head is dropped, not consumed twice.
  - The FIFO is empty the next cycle, so out_valid=0 for at least one cycle after a redirect.
- Each redirect cycle increments flush_count.
- FIFO:
  - out_* are driven combinationally from the head entry.
  - Dequeue when out_valid & out_ready & ~redirect.
  - Head and tail pointers are log2(DEPTH) bits and wrap naturally.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - Overflow is impossible because requests are issued only while count < DEPTH; the bench asserts count <= DEPTH.
- Latency: with a 1-cycle icache, the first instruction appears on out_valid 2 cycles after reset release. Steady-state throughput is one instruction per 2 cycles (single outstanding request).

Test Plan:
- Reset release, out_ready=1, imem_resp one cycle after each request with rdata=addr^32'hFFFF -> imem_address sequence 6000_0000, 6000_0004, ...; out_pc matches and out_ir=addr^FFFF; out_pc_next=out_pc+4.
- out_ready=0 for 20 cycles with DEPTH=4 -> exactly 4 entries enqueued, imem_read=0 in WAIT; after out_ready=1, in-order drain 6000_0000..6000_000C, then fetch resumes at 6000_0010.
- Redirect to 32'h6000_0103 while a request is pending and resp delayed 3 cycles -> imem_address held at the old value until resp, that data never appears on out_*, next request at 6000_0100, flush_count=1.
- Redirect in the same cycle as imem_resp and out_valid&out_ready -> no enqueue, no double dequeue, out_valid=0 the next cycle, next imem_address=target.
- Two back-to-back redirects (6000_0200 then 6000_0300) during DROP -> only 6000_0300 is fetched; flush_count=2.
- rst asserted mid-request with FIFO holding 3 entries -> out_valid=0 and imem_read=0 immediately (async); after release, fetch restarts at RESET_PC.
